// File: rtl/bg_line_feeder_if.sv
// Request/write bundle between one BG layer feeder and its neighbours:
// the mixer line sequencer, the BG pixel engine and the line buffer.
interface bg_line_feeder_if #(
  parameter int pW_WIDTH = 9,
  parameter int pH_WIDTH = 9
);
  logic                iLINE_START;
  logic [pH_WIDTH-1:0] iLINE_Y;
  logic                oBUSY;
  logic                oLINE_DONE;
  logic                oTIMEOUT;
  logic [pW_WIDTH-1:0] oX;
  logic [pH_WIDTH-1:0] oY;
  logic                oRGB_REQ;
  logic                iOFFSCREEN;
  logic                iRGB_WRITE;
  logic [15:0]         iRGB_WRITE_DATA;
  logic                oLB_WE;
  logic [pW_WIDTH-1:0] oLB_ADDR;
  logic [16:0]         oLB_DATA;

  // Feeder side
  modport master (
    input  iLINE_START, iLINE_Y, iOFFSCREEN, iRGB_WRITE, iRGB_WRITE_DATA,
    output oBUSY, oLINE_DONE, oTIMEOUT, oX, oY, oRGB_REQ,
           oLB_WE, oLB_ADDR, oLB_DATA
  );

  // Sequencer / BG / line-buffer side
  modport slave (
    output iLINE_START, iLINE_Y, iOFFSCREEN, iRGB_WRITE, iRGB_WRITE_DATA,
    input  oBUSY, oLINE_DONE, oTIMEOUT, oX, oY, oRGB_REQ,
           oLB_WE, oLB_ADDR, oLB_DATA
  );
endinterface

// File: rtl/bg_line_feeder.sv
// Walks one BG line pixel by pixel: request RGB, wait for the BG write strobe
// (or time out), and store {offscreen, RGB} into the line buffer at X.
module bg_line_feeder #(
  parameter int          pLINE_W   = 320,
  parameter int          pSETUP    = 2,
  parameter int          pTIMEOUT  = 1023,
  parameter logic [15:0] pFILL_RGB = 16'h0000,
  parameter int          pW_WIDTH  = 9,
  parameter int          pH_WIDTH  = 9
) (
  input logic             iCLOCK,
  input logic             iRESET_N,
  bg_line_feeder_if.master bus
);

  localparam int cSETUP_W = (pSETUP > 1) ? $clog2(pSETUP) : 1;
  localparam int cTMO_W   = $clog2(pTIMEOUT + 1);

  localparam logic [pW_WIDTH-1:0] cLAST_X     = pW_WIDTH'(pLINE_W - 1);
  localparam logic [cSETUP_W-1:0] cSETUP_LAST = cSETUP_W'(pSETUP - 1);
  localparam logic [cTMO_W-1:0]   cTMO_LAST   = cTMO_W'(pTIMEOUT - 1);

  typedef enum logic [2:0] {
    sIDLE,
    sSETUP,
    sREQ,
    sWAIT,
    sSTORE,
    sNEXT,
    sDONE
  } state_t;

  state_t              state_q, state_d;
  logic [pW_WIDTH-1:0] x_q, x_d;
  logic [pH_WIDTH-1:0] y_q, y_d;
  logic [cSETUP_W-1:0] setup_cnt_q, setup_cnt_d;
  logic [cTMO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [16:0]         data_q, data_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic                abort_q, abort_d;
  logic                wr_prev_q;
  logic                wr_rise;

  // Only a fresh rising strobe counts; a strobe held over from the previous
  // pixel (or arriving outside sWAIT) still updates the history.
  assign wr_rise = bus.iRGB_WRITE & ~wr_prev_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    setup_cnt_d = setup_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    data_d      = data_q;
    busy_d      = busy_q;
    timeout_d   = timeout_q;
    abort_d     = abort_q;

    case (state_q)
      sIDLE: begin
        if (bus.iLINE_START) begin
          y_d         = bus.iLINE_Y;
          x_d         = '0;
          timeout_d   = 1'b0;
          abort_d     = 1'b0;
          busy_d      = 1'b1;
          setup_cnt_d = '0;
          state_d     = sSETUP;
        end
      end

      sSETUP: begin
        if (setup_cnt_q == cSETUP_LAST) begin
          state_d = sREQ;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end

      sREQ: begin
        wait_cnt_d = '0;
        state_d    = sWAIT;
      end

      sWAIT: begin
        // A strobe landing on the timeout cycle is still a normal capture.
        if (wr_rise) begin
          data_d  = {bus.iOFFSCREEN, bus.iRGB_WRITE_DATA};
          state_d = sSTORE;
        end else if (wait_cnt_q == cTMO_LAST) begin
          data_d    = {1'b1, pFILL_RGB};
          timeout_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = sSTORE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      sSTORE: begin
        state_d = abort_q ? sDONE : sNEXT;
      end

      sNEXT: begin
        if (x_q == cLAST_X) begin
          state_d = sDONE;
        end else begin
          x_d         = x_q + 1'b1;
          setup_cnt_d = '0;
          state_d     = sSETUP;
        end
      end

      sDONE: begin
        busy_d  = 1'b0;
        state_d = sIDLE;
      end

      default: begin
        state_d = sIDLE;
      end
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (!iRESET_N) begin
      state_q     <= sIDLE;
      x_q         <= '0;
      y_q         <= '0;
      setup_cnt_q <= '0;
      wait_cnt_q  <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      abort_q     <= 1'b0;
      wr_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      setup_cnt_q <= setup_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      abort_q     <= abort_d;
      wr_prev_q   <= bus.iRGB_WRITE;
    end
  end

  // Line-buffer address/data are forced to zero except on the write cycle.
  assign bus.oLB_WE     = (state_q == sSTORE);
  assign bus.oLB_ADDR   = bus.oLB_WE ? x_q : '0;
  assign bus.oLB_DATA   = bus.oLB_WE ? data_q : '0;
  assign bus.oRGB_REQ   = (state_q == sREQ);
  assign bus.oLINE_DONE = (state_q == sDONE);
  assign bus.oBUSY      = busy_q;
  assign bus.oTIMEOUT   = timeout_q;
  assign bus.oX         = x_q;
  assign bus.oY         = y_q;

endmodule

// File: tb/tb_bg_line_feeder.sv
// Directed bench for bg_line_feeder: a BG responder model and a line-buffer
// scoreboard run inside the per-cycle tick of a single stimulus process.
module tb_bg_line_feeder;
  localparam int LINE_W = 320;
  localparam int TMO    = 1023;
  localparam int LAT    = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bg_line_feeder_if #(.pW_WIDTH(9), .pH_WIDTH(9)) bus ();

  bg_line_feeder #(
    .pLINE_W(LINE_W), .pSETUP(2), .pTIMEOUT(TMO), .pFILL_RGB(16'h0000),
    .pW_WIDTH(9), .pH_WIDTH(9)
  ) dut (
    .iCLOCK  (clk),
    .iRESET_N(rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_q[$];

  int cyc = 0;
  int req_cnt, we_cnt, done_cnt, max_req_x, first_req_x, last_req_x;
  int exp_y;
  int hold_cyc = 1;
  int silent_x = -1;
  bit offs_mode = 1'b0;
  int busy_start_x = -1;
  logic [8:0] busy_start_y = '0;
  int countdown = 0;
  int hold_left = 0;
  int resp_x = 0;
  int req_sil_cyc = 0;
  int we_sil_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] d;
    logic        off;
    logic [25:0] e;
    @(posedge clk);
    #1;
    cyc++;
    bus.iLINE_START = 1'b0;

    if (bus.oLB_WE) begin
      we_cnt++;
      if (int'(bus.oLB_ADDR) == silent_x) we_sil_cyc = cyc;
      check("lb_write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("lb_addr_data", {6'd0, bus.oLB_ADDR, bus.oLB_DATA}, {6'd0, e});
      end
    end
    if (bus.oLINE_DONE) done_cnt++;
    if (bus.oRGB_REQ) begin
      req_cnt++;
      last_req_x = int'(bus.oX);
      if (first_req_x < 0) first_req_x = int'(bus.oX);
      if (int'(bus.oX) > max_req_x) max_req_x = int'(bus.oX);
      check("req_y", 32'(bus.oY), 32'(exp_y));
      if (int'(bus.oX) == silent_x) begin
        req_sil_cyc = cyc;
        exp_q.push_back({bus.oX, 1'b1, 16'h0000});
      end else begin
        countdown = LAT;
        resp_x    = int'(bus.oX);
      end
      if (int'(bus.oX) == busy_start_x) begin
        bus.iLINE_START = 1'b1;
        bus.iLINE_Y     = busy_start_y;
      end
    end

    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        d   = 16'h1234 + 16'(resp_x);
        off = offs_mode && (resp_x < 4);
        bus.iRGB_WRITE      = 1'b1;
        bus.iRGB_WRITE_DATA = d;
        bus.iOFFSCREEN      = off;
        exp_q.push_back({9'(resp_x), off, d});
        hold_left = hold_cyc - 1;
      end
    end else if (hold_left > 0) begin
      hold_left--;
    end else begin
      bus.iRGB_WRITE = 1'b0;
      bus.iOFFSCREEN = 1'b0;
    end
  endtask

  task automatic start_line(input int y);
    req_cnt = 0; we_cnt = 0; done_cnt = 0;
    max_req_x = -1; first_req_x = -1; last_req_x = -1;
    exp_y = y;
    bus.iLINE_Y     = 9'(y);
    bus.iLINE_START = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    int start = done_cnt;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt != start), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.oBUSY),      32'd0);
    check({tag, "_done"},  32'(bus.oLINE_DONE), 32'd0);
    check({tag, "_tmo"},   32'(bus.oTIMEOUT),   32'd0);
    check({tag, "_x"},     32'(bus.oX),         32'd0);
    check({tag, "_y"},     32'(bus.oY),         32'd0);
    check({tag, "_req"},   32'(bus.oRGB_REQ),   32'd0);
    check({tag, "_we"},    32'(bus.oLB_WE),     32'd0);
    check({tag, "_addr"},  32'(bus.oLB_ADDR),   32'd0);
    check({tag, "_data"},  32'(bus.oLB_DATA),   32'd0);
  endtask

  initial begin
    int n;
    int snap_req, snap_we;
    rst_n = 1'b0;
    bus.iLINE_START = 1'b0; bus.iLINE_Y = '0;
    bus.iOFFSCREEN = 1'b0; bus.iRGB_WRITE = 1'b0; bus.iRGB_WRITE_DATA = '0;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: plain line Y=5, single-cycle strobe
    start_line(5);
    check("t1_busy_after_start", 32'(bus.oBUSY), 32'd1);
    wait_done(LINE_W * 20, "t1_done_in_time");
    tick();
    check("t1_we_cnt",   32'(we_cnt),       32'd320);
    check("t1_req_cnt",  32'(req_cnt),      32'd320);
    check("t1_max_x",    32'(max_req_x),    32'd319);
    check("t1_done_cnt", 32'(done_cnt),     32'd1);
    check("t1_timeout",  32'(bus.oTIMEOUT), 32'd0);
    check("t1_idle",     32'(bus.oBUSY),    32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2+3: two-cycle strobes, plus a start pulse with Y=9 while busy at X=10
    hold_cyc = 2;
    busy_start_x = 10; busy_start_y = 9'd9;
    start_line(5);
    wait_done(LINE_W * 20, "t2_done_in_time");
    busy_start_x = -1;
    repeat (10) tick();
    check("t2_we_cnt",   32'(we_cnt),       32'd320);
    check("t2_req_cnt",  32'(req_cnt),      32'd320);
    check("t2_done_cnt", 32'(done_cnt),     32'd1);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t3_y_kept",   32'(bus.oY),       32'd5);
    check("t3_no_restart", 32'(bus.oBUSY),  32'd0);
    hold_cyc = 1;

    // 4: BG silent at X=7 -> timeout fill, abort
    silent_x = 7;
    start_line(3);
    wait_done(3000, "t4_done_in_time");
    repeat (30) tick();
    check("t4_timeout",  32'(bus.oTIMEOUT), 32'd1);
    check("t4_req_cnt",  32'(req_cnt),      32'd8);
    check("t4_max_x",    32'(max_req_x),    32'd7);
    check("t4_we_cnt",   32'(we_cnt),       32'd8);
    check("t4_done_cnt", 32'(done_cnt),     32'd1);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t4_tmo_latency", 32'(we_sil_cyc - req_sil_cyc), 32'(TMO + 1));
    silent_x = -1;

    // 5: reset in sWAIT at X=100; start clears the sticky timeout
    start_line(11);
    repeat (3) tick();
    check("t5_tmo_cleared", 32'(bus.oTIMEOUT), 32'd0);
    n = 0;
    while (last_req_x != 100 && n < 2000) begin
      tick();
      n++;
    end
    check("t5_reached_x100", 32'(last_req_x), 32'd100);
    repeat (2) tick();
    check("t5_sb_empty_pre", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    countdown = 0; hold_left = 0;
    bus.iRGB_WRITE = 1'b0; bus.iOFFSCREEN = 1'b0;
    tick();
    check_all_zero("t5_reset");
    rst_n = 1'b1;
    snap_req = req_cnt; snap_we = we_cnt;
    repeat (20) tick();
    check("t5_no_req", 32'(req_cnt), 32'(snap_req));
    check("t5_no_we",  32'(we_cnt),  32'(snap_we));

    // 6: fresh line, offscreen at X=0..3
    offs_mode = 1'b1;
    start_line(2);
    wait_done(LINE_W * 20, "t6_done_in_time");
    tick();
    check("t6_first_x",  32'(first_req_x),  32'd0);
    check("t6_we_cnt",   32'(we_cnt),       32'd320);
    check("t6_done_cnt", 32'(done_cnt),     32'd1);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t6_timeout",  32'(bus.oTIMEOUT), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
